// File: rtl/step_sequencer_gen.sv
// Clock divider (period = speed * CLKS_PER_UNIT cycles) driving a step index with up/down/ping-pong/hold modes.
// Latency: all outputs registered; tick/wrap appear in the same cycle as the new step_out, P cycles after clear.
// Backpressure: none; en=0 freezes divider and step, speed=0 parks the divider. STEP_SEQ_PINGPONG_EN enables mode 10.
module step_sequencer_gen #(
  parameter int SPEED_W       = 9,
  parameter int CLKS_PER_UNIT = 1000000,
  parameter int DIV_W         = 30,
  parameter int STEP_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [SPEED_W-1:0] speed,
  input  logic [STEP_W-1:0] step_max,
  input  logic [1:0]        mode,
  output logic [DIV_W-1:0]  freq_div,
  output logic [STEP_W-1:0] step_out,
  output logic              tick,
  output logic              wrap,
  output logic              dir
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  // One extra bit so the period product and its comparison never truncate.
  localparam int              PW   = DIV_W + 1;
  localparam logic [PW-1:0]   UNIT = PW'(CLKS_PER_UNIT);

  logic [PW-1:0]     period;
  logic              speed_zero;
  logic              terminal;
  logic [1:0]        mode_eff;
  logic [STEP_W-1:0] step_inc;
  logic [STEP_W-1:0] step_dec;
  logic              at_or_above;
  logic              above;
  logic              max_zero;
  logic [STEP_W-1:0] adv_step;
  logic              adv_dir;
  logic              adv_wrap;

  assign period     = PW'(speed) * UNIT;
  assign speed_zero = (speed == '0);
  // >= rather than == so a speed decrease mid-count ends the period at the next edge.
  assign terminal   = ({1'b0, freq_div} >= (period - PW'(1)));

  assign step_inc    = step_out + STEP_W'(1);
  assign step_dec    = step_out - STEP_W'(1);
  assign at_or_above = (step_out >= step_max);
  assign above       = (step_out > step_max);
  assign max_zero    = (step_max == '0);

`ifdef STEP_SEQ_PINGPONG_EN
  assign mode_eff = mode;
`else
  // Without ping-pong support, mode 10 is simply another name for up.
  assign mode_eff = (mode == MODE_PP) ? MODE_UP : mode;
`endif

  // Next step/dir/wrap for an advancing edge, chosen by the mode in force at that edge.
  always_comb begin
    adv_step = step_out;
    adv_dir  = dir;
    adv_wrap = 1'b0;
    if (max_zero && (mode_eff != MODE_HOLD)) begin
      // One-step sequence: every tick completes it; ping-pong stays ascending.
      adv_step = '0;
      adv_wrap = 1'b1;
      adv_dir  = (mode_eff != MODE_DOWN);
    end else begin
      case (mode_eff)
        MODE_UP: begin
          adv_dir = 1'b1;
          if (at_or_above) begin
            adv_step = '0;
            adv_wrap = 1'b1;
          end else begin
            adv_step = step_inc;
          end
        end
        MODE_DOWN: begin
          adv_dir = 1'b0;
          if ((step_out == '0) || above) begin
            adv_step = step_max;
            adv_wrap = 1'b1;
          end else begin
            adv_step = step_dec;
          end
        end
`ifdef STEP_SEQ_PINGPONG_EN
        MODE_PP: begin
          if (dir) begin
            // Ascending leg saturates at step_max and turns around there.
            if (at_or_above) begin
              adv_step = step_max;
              adv_dir  = 1'b0;
            end else begin
              adv_step = step_inc;
              if (step_inc == step_max) begin
                adv_dir = 1'b0;
              end
            end
          end else begin
            // Descending leg: an out-of-range step snaps to step_max first.
            if (above) begin
              adv_step = step_max;
            end else begin
              adv_step = step_dec;
              if (step_dec == '0) begin
                adv_dir  = 1'b1;
                adv_wrap = 1'b1;
              end
            end
          end
        end
`endif
        default: begin
          // Hold: step and direction frozen, tick still pulses.
          adv_step = step_out;
          adv_dir  = dir;
          adv_wrap = 1'b0;
        end
      endcase
    end
  end

  // Divider, step register and strobes; clear outranks en, en=0 freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_div <= '0;
      step_out <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      dir      <= 1'b1;
    end else if (clear) begin
      freq_div <= '0;
      step_out <= (mode == MODE_DOWN) ? step_max : '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      dir      <= 1'b1;
    end else if (!en) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (speed_zero) begin
      freq_div <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end else if (terminal) begin
      freq_div <= '0;
      step_out <= adv_step;
      dir      <= adv_dir;
      tick     <= 1'b1;
      wrap     <= adv_wrap;
    end else begin
      freq_div <= freq_div + DIV_W'(1);
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_step_sequencer_gen.sv
// Bench for step_sequencer_gen with CLKS_PER_UNIT=4: directed vector table, reset corner case, randomized run vs model.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: not applicable; stimulus is free-running.
module tb_step_sequencer_gen;

  localparam int SPEED_W = 9;
  localparam int CPU     = 4;
  localparam int DIV_W   = 30;
  localparam int STEP_W  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               clear;
  logic [SPEED_W-1:0] speed;
  logic [STEP_W-1:0]  step_max;
  logic [1:0]         mode;
  logic [DIV_W-1:0]   freq_div;
  logic [STEP_W-1:0]  step_out;
  logic               tick;
  logic               wrap;
  logic               dir;

  int total = 0;
  int bad   = 0;

  // Reference state: what the outputs should read after the next edge.
  int m_div, m_step, m_dir, m_tick, m_wrap;

  step_sequencer_gen #(
    .SPEED_W(SPEED_W), .CLKS_PER_UNIT(CPU), .DIV_W(DIV_W), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .speed(speed),
    .step_max(step_max), .mode(mode), .freq_div(freq_div),
    .step_out(step_out), .tick(tick), .wrap(wrap), .dir(dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_div, input int e_step,
                           input int e_tick, input int e_wrap, input int e_dir);
    check({tag, "_div"},  32'(freq_div), e_div);
    check({tag, "_step"}, 32'(step_out), e_step);
    check({tag, "_tick"}, 32'(tick),     e_tick);
    check({tag, "_wrap"}, 32'(wrap),     e_wrap);
    check({tag, "_dir"},  32'(dir),      e_dir);
  endtask

  task automatic model_reset();
    m_div = 0; m_step = 0; m_tick = 0; m_wrap = 0; m_dir = 1;
  endtask

  // Behaviour of one rising edge, stated as the sequencing rules in plain integers.
  task automatic model_edge();
    int p, md, mx, s;
    mx = int'(step_max);
    s  = m_step;
    md = int'(mode);
    if (clear) begin
      m_div = 0; m_dir = 1; m_tick = 0; m_wrap = 0;
      m_step = (md == 1) ? mx : 0;
      return;
    end
    if (!en) begin
      m_tick = 0; m_wrap = 0;
      return;
    end
    if (speed == 0) begin
      m_div = 0; m_tick = 0; m_wrap = 0;
      return;
    end
    p = int'(speed) * CPU;
    if (m_div < p - 1) begin
      m_div++; m_tick = 0; m_wrap = 0;
      return;
    end
    m_div = 0; m_tick = 1; m_wrap = 0;
`ifndef STEP_SEQ_PINGPONG_EN
    if (md == 2) md = 0;
`endif
    if (md == 3) return;
    if (mx == 0) begin
      m_step = 0; m_wrap = 1; m_dir = (md == 1) ? 0 : 1;
      return;
    end
    case (md)
      0: begin
        m_dir = 1;
        if (s >= mx) begin m_step = 0; m_wrap = 1; end
        else m_step = s + 1;
      end
      1: begin
        m_dir = 0;
        if (s == 0 || s > mx) begin m_step = mx; m_wrap = 1; end
        else m_step = s - 1;
      end
      default: begin
        if (m_dir == 1) begin
          m_step = (s + 1 < mx) ? s + 1 : mx;
          if (m_step == mx) m_dir = 0;
        end else begin
          m_step = (s > mx) ? mx : (s + 15) % 16;
          if (m_step == 0) begin m_dir = 1; m_wrap = 1; end
        end
      end
    endcase
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic en;
    logic clear;
    int   speed;
    int   mx;
    int   mode;
    int   n;
    int   e_div;
    int   e_step;
    int   e_tick;
    int   e_wrap;
    int   e_dir;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic v_en, input logic v_clr, input int v_sp, input int v_mx,
                              input int v_md, input int v_n, input int e_div, input int e_step,
                              input int e_tick, input int e_wrap, input int e_dir);
    vec_t v;
    v.en = v_en; v.clear = v_clr; v.speed = v_sp; v.mx = v_mx; v.mode = v_md; v.n = v_n;
    v.e_div = e_div; v.e_step = e_step; v.e_tick = e_tick; v.e_wrap = e_wrap; v.e_dir = e_dir;
    vt.push_back(v);
  endfunction

  initial begin
    // Directed vectors; state carries from row to row. Speed 3 gives P = 12.
    add(1, 1,  3, 11, 0,   1,  0,  0, 0, 0, 1);
    add(1, 0,  3, 11, 0,  11, 11,  0, 0, 0, 1);
    add(1, 0,  3, 11, 0,   1,  0,  1, 1, 0, 1);
    add(1, 0,  3, 11, 0, 120,  0, 11, 1, 0, 1);
    add(1, 0,  3, 11, 0,  12,  0,  0, 1, 1, 1);
    add(1, 0,  3, 11, 0,   1,  1,  0, 0, 0, 1);
    add(1, 1,  3,  5, 1,   1,  0,  5, 0, 0, 1);
    add(1, 0,  3,  5, 1,  12,  0,  4, 1, 0, 0);
    add(1, 0,  3,  5, 1,  48,  0,  0, 1, 0, 0);
    add(1, 0,  3,  5, 1,  12,  0,  5, 1, 1, 0);
    add(1, 1,  3,  3, 2,   1,  0,  0, 0, 0, 1);
`ifdef STEP_SEQ_PINGPONG_EN
    add(1, 0,  3,  3, 2,  36,  0,  3, 1, 0, 0);
    add(1, 0,  3,  3, 2,  12,  0,  2, 1, 0, 0);
    add(1, 0,  3,  3, 2,  24,  0,  0, 1, 1, 1);
    add(1, 0,  3,  3, 2,  12,  0,  1, 1, 0, 1);
`else
    add(1, 0,  3,  3, 2,  36,  0,  3, 1, 0, 1);
    add(1, 0,  3,  3, 2,  12,  0,  0, 1, 1, 1);
    add(1, 0,  3,  3, 2,  24,  0,  2, 1, 0, 1);
    add(1, 0,  3,  3, 2,  12,  0,  3, 1, 0, 1);
`endif
    add(1, 1,  3, 11, 0,   1,  0,  0, 0, 0, 1);
    add(1, 0,  3, 11, 0,   5,  5,  0, 0, 0, 1);
    add(0, 0,  3, 11, 0,   7,  5,  0, 0, 0, 1);
    add(1, 0,  3, 11, 0,   6, 11,  0, 0, 0, 1);
    add(1, 0,  3, 11, 0,   1,  0,  1, 1, 0, 1);
    add(0, 1,  3, 11, 0,   1,  0,  0, 0, 0, 1);
    add(1, 0, 10, 11, 0,  25, 25,  0, 0, 0, 1);
    add(1, 0,  2, 11, 0,   1,  0,  1, 1, 0, 1);
    add(1, 0,  2, 11, 0,   7,  7,  1, 0, 0, 1);
    add(1, 0,  2, 11, 0,   1,  0,  2, 1, 0, 1);
    add(1, 0,  0, 11, 0,  20,  0,  2, 0, 0, 1);
    add(1, 0,  3, 11, 0,  84,  0,  9, 1, 0, 1);
    add(1, 0,  3,  4, 0,  12,  0,  0, 1, 1, 1);
    add(1, 0,  3,  0, 2,  12,  0,  0, 1, 1, 1);
    add(1, 0,  3,  0, 1,  12,  0,  0, 1, 1, 0);
    add(1, 0,  3,  0, 3,  12,  0,  0, 1, 0, 0);

    // Reset state.
    rst = 1'b1; en = 1'b0; clear = 1'b0; speed = 9'd3; step_max = 4'd11; mode = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset", 0, 0, 0, 0, 1);

    // Table-driven vectors.
    for (int i = 0; i < vt.size(); i++) begin
      en       = vt[i].en;
      clear    = vt[i].clear;
      speed    = SPEED_W'(vt[i].speed);
      step_max = STEP_W'(vt[i].mx);
      mode     = 2'(vt[i].mode);
      for (int k = 0; k < vt[i].n; k++) cyc();
      check_all($sformatf("vec%0d", i), vt[i].e_div, vt[i].e_step,
                vt[i].e_tick, vt[i].e_wrap, vt[i].e_dir);
    end

    // Async reset mid-period: outputs drop before the next edge, count restarts after release.
    en = 1'b1; clear = 1'b0; speed = 9'd3; step_max = 4'd11; mode = 2'b00;
    for (int k = 0; k < 5; k++) cyc();
    check("pre_rst_div", 32'(freq_div), 5);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst", 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    check("post_rst_div", 32'(freq_div), 1);

    // Randomized run against the reference model, checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) speed = SPEED_W'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) step_max = STEP_W'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      cyc();
      check_all($sformatf("rnd%0d", c), m_div, m_step, m_tick, m_wrap, m_dir);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
